// File: rtl/mcu_spi_select_pkg.sv
// Shared types and default timing constants for the MCU SPI source selector.
package mcu_sel_pkg;

  typedef enum logic [2:0] {
    StInt,
    StArm,
    StWaitIdle,
    StGap,
    StExt
  } sel_state_e;

  localparam int unsigned DefDetCycles  = 16;
  localparam int unsigned DefIdleCycles = 8;
  localparam int unsigned DefGapCycles  = 4;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mcu_spi_select_if.sv
// Board-pin and core-side SPI signals of the MCU selector, grouped as one bundle.
interface mcu_spi_select_if;
  logic int_sclk;
  logic int_csn;
  logic int_mosi;
  logic ext_sclk;
  logic ext_csn;
  logic ext_mosi;
  logic core_miso;
  logic core_intn;
  logic mcu_sclk;
  logic mcu_csn;
  logic mcu_mosi;
  logic miso_out;
  logic intn_out;
  logic spi_ext;
  logic switched;

  modport master (
    output int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi, core_miso, core_intn,
    input  mcu_sclk, mcu_csn, mcu_mosi, miso_out, intn_out, spi_ext, switched
  );

  modport slave (
    input  int_sclk, int_csn, int_mosi, ext_sclk, ext_csn, ext_mosi, core_miso, core_intn,
    output mcu_sclk, mcu_csn, mcu_mosi, miso_out, intn_out, spi_ext, switched
  );
endinterface

// File: rtl/mcu_spi_select_sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RstVal;
      s2_q <= RstVal;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/mcu_spi_select.sv
// Picks the BL616 or an M0S dock as control-SPI master; debounced detect, frame-safe
// one-way switchover and a forced chip-select gap at the switch.
module mcu_spi_select
  import mcu_sel_pkg::*;
#(
  parameter int unsigned DET_CYCLES  = DefDetCycles,
  parameter int unsigned IDLE_CYCLES = DefIdleCycles,
  parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
  input logic              clk32,
  input logic              por,
  mcu_spi_select_if.slave  bus
);
  localparam int unsigned CntW = $clog2(max3(DET_CYCLES, IDLE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0] DetMax  = CntW'(DET_CYCLES);
  localparam logic [CntW-1:0] IdleMax = CntW'(IDLE_CYCLES);
  localparam logic [CntW-1:0] GapMax  = CntW'(GAP_CYCLES);

  sel_state_e      state_q;
  logic            sel_q, switched_q;
  logic [CntW-1:0] det_q, idle_q, gap_q;
  logic [CntW-1:0] det_inc, idle_inc, gap_dec;
  logic            ext_csn_s, int_csn_s;

  sync2 #(.RstVal(1'b1)) u_sync_ext (.clk(clk32), .rst(por), .d(bus.ext_csn), .q(ext_csn_s));
  sync2 #(.RstVal(1'b1)) u_sync_int (.clk(clk32), .rst(por), .d(bus.int_csn), .q(int_csn_s));

  // Saturating steps so no counter can wrap.
  assign det_inc  = (det_q == CntMax) ? det_q : det_q + 1'b1;
  assign idle_inc = (idle_q == CntMax) ? idle_q : idle_q + 1'b1;
  assign gap_dec  = (gap_q == '0) ? gap_q : gap_q - 1'b1;

  always_ff @(posedge clk32) begin
    if (por) begin
      state_q    <= StInt;
      sel_q      <= 1'b0;
      switched_q <= 1'b0;
      det_q      <= '0;
      idle_q     <= '0;
      gap_q      <= '0;
    end else begin
      switched_q <= 1'b0;
      unique case (state_q)
        StInt: begin
          if (!ext_csn_s) begin
            state_q <= StArm;
            det_q   <= CntW'(1);
          end
        end
        StArm: begin
          if (ext_csn_s) begin
            state_q <= StInt;
            det_q   <= '0;
          end else begin
            det_q <= det_inc;
            if (det_inc >= DetMax) begin
              state_q <= StWaitIdle;
              idle_q  <= '0;
            end
          end
        end
        StWaitIdle: begin
          // A falling int_csn always clears, even on the cycle that would commit.
          if (!int_csn_s) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_inc;
            if (idle_inc >= IdleMax) begin
              state_q    <= StGap;
              sel_q      <= 1'b1;
              gap_q      <= GapMax;
              switched_q <= 1'b1;
            end
          end
        end
        StGap: begin
          gap_q <= gap_dec;
          if (gap_dec == '0) state_q <= StExt;
        end
        StExt: begin
        end
        default: state_q <= StInt;
      endcase
    end
  end

  assign bus.mcu_sclk = sel_q ? bus.ext_sclk : bus.int_sclk;
  assign bus.mcu_mosi = sel_q ? bus.ext_mosi : bus.int_mosi;
  assign bus.mcu_csn  = (gap_q != '0) | (sel_q ? bus.ext_csn : bus.int_csn);
  assign bus.miso_out = bus.core_miso;
  assign bus.intn_out = bus.core_intn;
  assign bus.spi_ext  = sel_q;
  assign bus.switched = switched_q;
endmodule

// File: tb/tb_mcu_spi_select.sv
// Table-driven and randomised checks of the MCU SPI selector against a timestamp model.
module tb_mcu_spi_select;
  localparam int MaxN = 2048;
  localparam int Det  = 16;
  localparam int Idle = 8;
  localparam int Gap  = 4;

  logic clk32 = 1'b0;
  logic por   = 1'b1;

  mcu_spi_select_if bus();

  mcu_spi_select #(
    .DET_CYCLES (Det),
    .IDLE_CYCLES(Idle),
    .GAP_CYCLES (Gap)
  ) dut (
    .clk32(clk32),
    .por  (por),
    .bus  (bus)
  );

  always #5 clk32 = ~clk32;

  int   total = 0;
  int   bad   = 0;
  int   pulses;
  logic ext_arr [MaxN];
  logic int_arr [MaxN];

  typedef struct {
    string name;
    int    n;
    int    ext_low;
    int    lo_start;
    int    lo_len;
    int    period;
    int    exp_ts;
  } vec_t;

  // Cycle t's inputs reach the FSM through two sync flops, so they act at edge t+3.
  // Detection: DET consecutive low ext samples; then IDLE consecutive high int samples.
  function automatic int model_switch(input int n);
    int run;
    int lat;
    lat = -1;
    run = 0;
    for (int e = 1; e < n && lat < 0; e++) begin
      if (e >= 3 && ext_arr[e-3] == 1'b0) run++;
      else run = 0;
      if (run == Det) lat = e;
    end
    if (lat < 0) return -1;
    run = 0;
    for (int e = lat + 1; e < n; e++) begin
      if (int_arr[e-3] == 1'b1) run++;
      else run = 0;
      if (run == Idle) return e;
    end
    return -1;
  endfunction

  task automatic do_reset();
    por = 1'b1;
    @(posedge clk32);
    #1;
    por = 1'b0;
  endtask

  task automatic check_cycle(input string name, input int t, input int ts);
    logic       sel_e, gap_e;
    logic [6:0] exp_v, got_v;
    sel_e = (ts >= 0) && (t >= ts);
    gap_e = sel_e && (t < ts + Gap);
    exp_v = {sel_e, (t == ts),
             sel_e ? bus.ext_sclk : bus.int_sclk,
             gap_e | (sel_e ? bus.ext_csn : bus.int_csn),
             sel_e ? bus.ext_mosi : bus.int_mosi,
             bus.core_miso, bus.core_intn};
    got_v = {bus.spi_ext, bus.switched, bus.mcu_sclk, bus.mcu_csn, bus.mcu_mosi,
             bus.miso_out, bus.intn_out};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s t=%0d {spi_ext,switched,sclk,csn,mosi,miso,intn} got=%b exp=%b",
               name, t, got_v, exp_v);
    end
  endtask

  task automatic run_ep(input string name, input int n, input int ts);
    int exp_p;
    pulses = 0;
    for (int t = 0; t < n; t++) begin
      bus.ext_csn   = ext_arr[t];
      bus.int_csn   = int_arr[t];
      bus.int_sclk  = 1'($urandom);
      bus.int_mosi  = 1'($urandom);
      bus.ext_sclk  = 1'($urandom);
      bus.ext_mosi  = 1'($urandom);
      bus.core_miso = 1'($urandom);
      bus.core_intn = 1'($urandom);
      #3;
      check_cycle(name, t, ts);
      if (bus.switched === 1'b1) pulses++;
      @(posedge clk32);
      #1;
    end
    exp_p = (ts >= 0 && ts < n) ? 1 : 0;
    total++;
    if (pulses != exp_p) begin
      bad++;
      $display("FAIL %s switched_pulses got=%0d exp=%0d", name, pulses, exp_p);
    end
  endtask

  task automatic fill(input vec_t v);
    for (int t = 0; t < MaxN; t++) begin
      ext_arr[t] = (t < v.ext_low) ? 1'b0 : 1'b1;
      if (v.period > 0)
        int_arr[t] = (t >= v.lo_start && ((t - v.lo_start) % v.period) < v.lo_len) ? 1'b0 : 1'b1;
      else
        int_arr[t] = (t >= v.lo_start && t < v.lo_start + v.lo_len) ? 1'b0 : 1'b1;
    end
  endtask

  vec_t vecs [8];

  initial begin
    bus.int_sclk  = 1'b0;
    bus.int_csn   = 1'b1;
    bus.int_mosi  = 1'b0;
    bus.ext_sclk  = 1'b0;
    bus.ext_csn   = 1'b1;
    bus.ext_mosi  = 1'b0;
    bus.core_miso = 1'b0;
    bus.core_intn = 1'b1;

    vecs[0] = '{"no_dock",      2000, 0,   2,  12,  20, -1};
    vecs[1] = '{"glitch10",     60,   10,  0,  0,   0,  -1};
    vecs[2] = '{"glitch15",     60,   15,  0,  0,   0,  -1};
    vecs[3] = '{"det16",        60,   16,  0,  0,   0,  26};
    vecs[4] = '{"clean",        60,   60,  0,  0,   0,  26};
    vecs[5] = '{"mid_frame",    260,  260, 0,  200, 0,  210};
    vecs[6] = '{"idle_restart", 60,   60,  23, 1,   0,  34};
    vecs[7] = '{"idle_early",   60,   60,  22, 1,   0,  33};

    do_reset();
    bus.int_csn = 1'b0;
    #3;
    total++;
    if (bus.spi_ext !== 1'b0 || bus.switched !== 1'b0 || bus.mcu_csn !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got spi_ext=%b switched=%b mcu_csn=%b exp 0 0 0",
               bus.spi_ext, bus.switched, bus.mcu_csn);
    end
    @(posedge clk32);
    #1;

    foreach (vecs[i]) begin
      fill(vecs[i]);
      do_reset();
      run_ep(vecs[i].name, vecs[i].n, vecs[i].exp_ts);
    end

    // por during the gap: select drops at once and detection restarts from scratch.
    fill(vecs[4]);
    do_reset();
    run_ep("pre_gap", 28, 26);
    do_reset();
    run_ep("post_por", 40, 26);

    for (int ep = 0; ep < 20; ep++) begin
      int idx;
      int len;
      int ts;
      idx = 0;
      while (idx < MaxN) begin
        len = $urandom_range(0, 25);
        for (int k = 0; k < len && idx < MaxN; k++) ext_arr[idx++] = 1'b1;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 20);
        for (int k = 0; k < len && idx < MaxN; k++) ext_arr[idx++] = 1'b0;
      end
      idx = 0;
      while (idx < MaxN) begin
        len = $urandom_range(1, 14);
        for (int k = 0; k < len && idx < MaxN; k++) int_arr[idx++] = 1'b1;
        len = $urandom_range(1, 20);
        for (int k = 0; k < len && idx < MaxN; k++) int_arr[idx++] = 1'b0;
      end
      ts = model_switch(150);
      do_reset();
      run_ep("random", 150, ts);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
